// File: rtl/cordic_pkg.sv
// Shared definitions for the summation datapath stages: FSM states,
// Q2.20 fixed-point format constants and default FP unit latencies.
package cordic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned FRAC_BITS       = 20;
    localparam int unsigned CORDIC_WIDTH    = 22;
    localparam int unsigned FLT_WIDTH       = 32;
    localparam int unsigned DEF_MUL_LATENCY = 3;
    localparam int unsigned DEF_ADD_LATENCY = 3;

endpackage

// File: rtl/fix22_to_fp32.sv
// Exact signed fixed-point to IEEE-754 single conversion (purely combinational).
module fix22_to_fp32
    import cordic_pkg::*;
#(
    parameter int unsigned FIX_W = CORDIC_WIDTH,
    parameter int unsigned FRAC  = FRAC_BITS
) (
    input  logic [FIX_W-1:0] fix_i,
    output logic [31:0]      flt_o
);

    logic             sign;
    logic [FIX_W-1:0] mag;
    int unsigned      msb;
    logic [31:0]      shifted;

    always_comb begin
        sign    = fix_i[FIX_W-1];
        mag     = sign ? (~fix_i + 1'b1) : fix_i;
        msb     = 0;
        for (int unsigned i = 0; i < FIX_W; i++) begin
            if (mag[i]) msb = i;
        end
        // FIX_W <= 24 keeps every significant bit inside the 23-bit fraction
        shifted = 32'(mag) << (23 - msb);
        flt_o   = '0;
        if (mag != '0) begin
            flt_o = {sign, 8'(int'(127 + msb) - int'(FRAC)), shifted[22:0]};
        end
    end

endmodule

// File: rtl/fp_add.sv
// Pipelined single-precision adder, round-to-nearest-even, denormals flushed.
module fp_add #(
    parameter int unsigned LATENCY = 3
) (
    input  logic        clk_i,
    input  logic        en_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] y_o
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap;
    logic        s_big, s_sml, inc;
    logic [7:0]  e_big, e_sml, d;
    logic [26:0] m_big, m_sml, m_al, norm;
    logic [27:0] sum;
    logic [24:0] rnd;
    logic [22:0] mant;
    int unsigned msb;
    int          e_res;
    logic [31:0] y_d;
    logic [31:0] pipe_q [LATENCY];

    always_comb begin
        a_nan  = (a_i[30:23] == 8'hFF) && (a_i[22:0] != '0);
        b_nan  = (b_i[30:23] == 8'hFF) && (b_i[22:0] != '0);
        a_inf  = (a_i[30:23] == 8'hFF) && (a_i[22:0] == '0);
        b_inf  = (b_i[30:23] == 8'hFF) && (b_i[22:0] == '0);
        a_zero = (a_i[30:23] == '0);
        b_zero = (b_i[30:23] == '0);

        swap  = b_i[30:0] > a_i[30:0];
        s_big = swap ? b_i[31] : a_i[31];
        s_sml = swap ? a_i[31] : b_i[31];
        e_big = swap ? b_i[30:23] : a_i[30:23];
        e_sml = swap ? a_i[30:23] : b_i[30:23];
        m_big = {1'b1, (swap ? b_i[22:0] : a_i[22:0]), 3'b000};
        m_sml = {1'b1, (swap ? a_i[22:0] : b_i[22:0]), 3'b000};
        d     = e_big - e_sml;

        // guard/round bits plus a sticky bit collecting everything shifted out
        if (d >= 8'd27) m_al = 27'd1;
        else m_al = (m_sml >> d) | {26'b0, |(m_sml & ((27'd1 << d) - 27'd1))};

        if (s_big == s_sml) sum = {1'b0, m_big} + {1'b0, m_al};
        else                sum = {1'b0, m_big} - {1'b0, m_al};

        msb = 0;
        for (int unsigned i = 0; i < 27; i++) begin
            if (sum[i]) msb = i;
        end

        e_res = int'(e_big);
        if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            e_res = e_res + 1;
        end else begin
            norm  = sum[26:0] << (26 - msb);
            e_res = e_res - 26 + int'(msb);
        end

        inc  = norm[2] & (norm[1] | norm[0] | norm[3]);
        rnd  = {1'b0, norm[26:3]} + 25'(inc);
        mant = rnd[24] ? rnd[23:1] : rnd[22:0];
        if (rnd[24]) e_res = e_res + 1;

        if (a_nan || b_nan || (a_inf && b_inf && (a_i[31] != b_i[31]))) y_d = QNAN;
        else if (a_inf)            y_d = a_i;
        else if (b_inf)            y_d = b_i;
        else if (a_zero && b_zero) y_d = {a_i[31] & b_i[31], 31'b0};
        else if (a_zero)           y_d = b_i;
        else if (b_zero)           y_d = a_i;
        else if (sum == '0)        y_d = '0;
        else if (e_res >= 255)     y_d = {s_big, 8'hFF, 23'b0};
        else if (e_res <= 0)       y_d = {s_big, 31'b0};
        else                       y_d = {s_big, 8'(e_res), mant};
    end

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            pipe_q[0] <= y_d;
            for (int unsigned i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign y_o = pipe_q[LATENCY-1];

endmodule

// File: rtl/fp_mul.sv
// Pipelined single-precision multiplier, round-to-nearest-even, denormals flushed.
module fp_mul #(
    parameter int unsigned LATENCY = 3
) (
    input  logic        clk_i,
    input  logic        en_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] y_o
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic [7:0]  ea, eb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, s;
    logic [23:0] ma, mb;
    logic [47:0] prod;
    logic [22:0] mant;
    logic        g, st, inc;
    logic [23:0] rnd;
    int          e_res;
    logic [31:0] y_d;
    logic [31:0] pipe_q [LATENCY];

    always_comb begin
        ea     = a_i[30:23];
        eb     = b_i[30:23];
        a_nan  = (ea == 8'hFF) && (a_i[22:0] != '0);
        b_nan  = (eb == 8'hFF) && (b_i[22:0] != '0);
        a_inf  = (ea == 8'hFF) && (a_i[22:0] == '0);
        b_inf  = (eb == 8'hFF) && (b_i[22:0] == '0);
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        s      = a_i[31] ^ b_i[31];
        ma     = {1'b1, a_i[22:0]};
        mb     = {1'b1, b_i[22:0]};
        prod   = 48'(ma) * 48'(mb);
        e_res  = int'(ea) + int'(eb) - 127;
        if (prod[47]) begin
            mant  = prod[46:24];
            g     = prod[23];
            st    = |prod[22:0];
            e_res = e_res + 1;
        end else begin
            mant  = prod[45:23];
            g     = prod[22];
            st    = |prod[21:0];
        end
        inc = g & (st | mant[0]);
        rnd = {1'b0, mant} + 24'(inc);
        if (rnd[23]) e_res = e_res + 1;

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) y_d = QNAN;
        else if (a_inf || b_inf)  y_d = {s, 8'hFF, 23'b0};
        else if (a_zero || b_zero) y_d = {s, 31'b0};
        else if (e_res >= 255)    y_d = {s, 8'hFF, 23'b0};
        else if (e_res <= 0)      y_d = {s, 31'b0};
        else                      y_d = {s, 8'(e_res), rnd[22:0]};
    end

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            pipe_q[0] <= y_d;
            for (int unsigned i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign y_o = pipe_q[LATENCY-1];

endmodule

// File: rtl/stage_2_combine.sv
// Computes sum(half_i + square_i * cos_i) for three operand sets using one shared
// FP multiplier and one shared FP adder under a fixed, counter-driven schedule.
module stage_2_combine
    import cordic_pkg::*;
#(
    parameter int unsigned FLT_DATA_WIDTH    = FLT_WIDTH,
    parameter int unsigned CORDIC_DATA_WIDTH = CORDIC_WIDTH,
    parameter int unsigned MUL_LATENCY       = DEF_MUL_LATENCY,
    parameter int unsigned ADD_LATENCY       = DEF_ADD_LATENCY
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clk_en,
    input  logic                         start,
    input  logic [CORDIC_DATA_WIDTH-1:0] cos_one,
    input  logic [CORDIC_DATA_WIDTH-1:0] cos_two,
    input  logic [CORDIC_DATA_WIDTH-1:0] cos_three,
    input  logic [FLT_DATA_WIDTH-1:0]    half_one,
    input  logic [FLT_DATA_WIDTH-1:0]    half_two,
    input  logic [FLT_DATA_WIDTH-1:0]    half_three,
    input  logic [FLT_DATA_WIDTH-1:0]    square_one,
    input  logic [FLT_DATA_WIDTH-1:0]    square_two,
    input  logic [FLT_DATA_WIDTH-1:0]    square_three,
    output logic [FLT_DATA_WIDTH-1:0]    result,
    output logic                         done
);

    localparam int unsigned ML     = MUL_LATENCY;
    localparam int unsigned AL     = ADD_LATENCY;
    localparam int unsigned LAST_K = 1 + ML + 3 * AL;
    localparam int unsigned KW     = $clog2(LAST_K + 1);

    // k counts RUN cycles; k = 0 is the first cycle after start is accepted
    localparam logic [KW-1:0] K_MUL_END = KW'(3);
    localparam logic [KW-1:0] K_ADD0    = KW'(ML);
    localparam logic [KW-1:0] K_ADD2    = KW'(ML + 2);
    localparam logic [KW-1:0] K_TERM0   = KW'(ML + AL);
    localparam logic [KW-1:0] K_SUM01   = KW'(1 + ML + AL);
    localparam logic [KW-1:0] K_FINAL   = KW'(1 + ML + 2 * AL);
    localparam logic [KW-1:0] K_LAST    = KW'(LAST_K);

    state_e                        state_q, state_d;
    logic [KW-1:0]                 k_q, k_d;
    logic                          latch_en;
    logic [CORDIC_DATA_WIDTH-1:0]  cos_q    [3];
    logic [FLT_DATA_WIDTH-1:0]     half_q   [3];
    logic [FLT_DATA_WIDTH-1:0]     square_q [3];
    logic [FLT_DATA_WIDTH-1:0]     term_q   [3];
    logic [FLT_DATA_WIDTH-1:0]     term_d   [3];
    logic [FLT_DATA_WIDTH-1:0]     sum01_q, sum01_d;
    logic [FLT_DATA_WIDTH-1:0]     result_q, result_d;

    logic [1:0]                    mul_sel;
    logic [CORDIC_DATA_WIDTH-1:0]  conv_in;
    logic [31:0]                   conv_out;
    logic [31:0]                   mul_a, mul_y;
    logic [31:0]                   add_a, add_b, add_y;

    fix22_to_fp32 #(
        .FIX_W (CORDIC_DATA_WIDTH),
        .FRAC  (FRAC_BITS)
    ) u_conv (
        .fix_i (conv_in),
        .flt_o (conv_out)
    );

    fp_mul #(
        .LATENCY (MUL_LATENCY)
    ) u_mul (
        .clk_i (clk),
        .en_i  (clk_en),
        .a_i   (mul_a),
        .b_i   (conv_out),
        .y_o   (mul_y)
    );

    fp_add #(
        .LATENCY (ADD_LATENCY)
    ) u_add (
        .clk_i (clk),
        .en_i  (clk_en),
        .a_i   (add_a),
        .b_i   (add_b),
        .y_o   (add_y)
    );

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        result_d = result_q;
        term_d   = term_q;
        sum01_d  = sum01_q;
        latch_en = 1'b0;
        done     = 1'b0;
        if (clk_en) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d  = ST_RUN;
                        k_d      = '0;
                        latch_en = 1'b1;
                    end
                end
                ST_RUN: begin
                    k_d = k_q + 1'b1;
                    if (k_q == K_TERM0)        term_d[0] = add_y;
                    if (k_q == K_TERM0 + 1'b1) term_d[1] = add_y;
                    if (k_q == K_TERM0 + 2'd2) term_d[2] = add_y;
                    if (k_q == K_FINAL)        sum01_d   = add_y;
                    if (k_q == K_LAST) begin
                        result_d = add_y;
                        state_d  = ST_DONE;
                    end
                end
                ST_DONE: begin
                    done    = !rst;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mul_sel = (k_q < K_MUL_END) ? 2'(k_q) : 2'd0;
        conv_in = cos_q[mul_sel];
        mul_a   = square_q[mul_sel];
    end

    // Operands that retire on the adder in the same cycle they are needed are
    // taken from the capture path (_d), so no extra bypass cycle is spent.
    always_comb begin
        add_a = '0;
        add_b = '0;
        if (k_q >= K_ADD0 && k_q <= K_ADD2) begin
            add_a = half_q[2'(k_q - K_ADD0)];
            add_b = mul_y;
        end else if (k_q == K_SUM01) begin
            add_a = term_d[0];
            add_b = term_d[1];
        end else if (k_q == K_FINAL) begin
            add_a = sum01_d;
            add_b = term_d[2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            result_q <= '0;
            sum01_q  <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                cos_q[i]    <= '0;
                half_q[i]   <= '0;
                square_q[i] <= '0;
                term_q[i]   <= '0;
            end
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            result_q <= result_d;
            sum01_q  <= sum01_d;
            term_q   <= term_d;
            if (latch_en) begin
                cos_q[0]    <= cos_one;
                cos_q[1]    <= cos_two;
                cos_q[2]    <= cos_three;
                half_q[0]   <= half_one;
                half_q[1]   <= half_two;
                half_q[2]   <= half_three;
                square_q[0] <= square_one;
                square_q[1] <= square_two;
                square_q[2] <= square_three;
            end
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_stage_2_combine.sv
// Directed bench for stage_2_combine: real-arithmetic reference model checked every
// cycle, plus literal result/latency expectations per operation.
module tb_stage_2_combine;

    localparam int ML       = 3;
    localparam int AL       = 3;
    localparam int DONE_LAT = 3 + ML + 3 * AL;

    logic        clk = 1'b0;
    logic        rst, clk_en, start;
    logic [21:0] cos_one, cos_two, cos_three;
    logic [31:0] half_one, half_two, half_three;
    logic [31:0] square_one, square_two, square_three;
    logic [31:0] result;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stage_2_combine #(
        .FLT_DATA_WIDTH    (32),
        .CORDIC_DATA_WIDTH (22),
        .MUL_LATENCY       (ML),
        .ADD_LATENCY       (AL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_en       (clk_en),
        .start        (start),
        .cos_one      (cos_one),
        .cos_two      (cos_two),
        .cos_three    (cos_three),
        .half_one     (half_one),
        .half_two     (half_two),
        .half_three   (half_three),
        .square_one   (square_one),
        .square_two   (square_two),
        .square_three (square_three),
        .result       (result),
        .done         (done)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:23] == 8'h00) return 0.0;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return b[31] ? -m : m;
    endfunction

    function automatic real q2r(input logic [21:0] c);
        return real'($signed(c)) / 1048576.0;
    endfunction

    function automatic logic [31:0] r2f(input real v);
        real    a;
        int     e;
        logic   s;
        longint f;
        if (v == 0.0) return '0;
        s = (v < 0.0);
        a = s ? -v : v;
        e = 127;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        f = longint'((a - 1.0) * 8388608.0);
        return {s, e[7:0], f[22:0]};
    endfunction

    function automatic logic [31:0] model_sum();
        real t0, t1, t2;
        t0 = f2r(half_one)   + f2r(square_one)   * q2r(cos_one);
        t1 = f2r(half_two)   + f2r(square_two)   * q2r(cos_two);
        t2 = f2r(half_three) + f2r(square_three) * q2r(cos_three);
        return r2f((t0 + t1) + t2);
    endfunction

    // Reference: an accepted op completes after DONE_LAT enabled cycles
    bit          m_busy    = 1'b0;
    int          m_cnt     = 0;
    logic [31:0] m_result  = '0;
    logic [31:0] m_pending = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy   <= 1'b0;
            m_cnt    <= 0;
            m_result <= '0;
        end else if (clk_en) begin
            if (!m_busy) begin
                if (start) begin
                    m_busy    <= 1'b1;
                    m_cnt     <= 1;
                    m_pending <= model_sum();
                end
            end else if (m_cnt == DONE_LAT) begin
                m_busy <= 1'b0;
            end else begin
                m_cnt <= m_cnt + 1;
                if (m_cnt + 1 == DONE_LAT) m_result <= m_pending;
            end
        end
    end

    always @(negedge clk) begin
        check32("done_cyc", {31'b0, done},
                {31'b0, (m_busy && m_cnt == DONE_LAT && clk_en && !rst)});
        check32("result_cyc", result, m_result);
    end

    task automatic set_ops(input logic [0:2][21:0] c, input logic [0:2][31:0] h,
                           input logic [0:2][31:0] s);
        cos_one    = c[0]; cos_two    = c[1]; cos_three    = c[2];
        half_one   = h[0]; half_two   = h[1]; half_three   = h[2];
        square_one = s[0]; square_two = s[1]; square_three = s[2];
    endtask

    task automatic scramble();
        cos_one    = 22'($urandom); cos_two    = 22'($urandom); cos_three    = 22'($urandom);
        half_one   = $urandom;      half_two   = $urandom;      half_three   = $urandom;
        square_one = $urandom;      square_two = $urandom;      square_three = $urandom;
    endtask

    // Called at posedge+1; start is accepted at the end of the current cycle (c).
    task automatic do_op(input string name, input logic [0:2][21:0] c,
                         input logic [0:2][31:0] h, input logic [0:2][31:0] s,
                         input logic [31:0] exp_res, input int exp_lat,
                         input int stall_at, input int stall_len, input int repulse_at);
        int lat;
        set_ops(c, h, s);
        start = 1'b1;
        @(negedge clk);
        check32({name, "_idle_done"}, {31'b0, done}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        scramble();
        for (lat = 1; lat < 100; lat++) begin
            clk_en = !(stall_len > 0 && lat >= stall_at && lat < stall_at + stall_len);
            start  = (lat == repulse_at);
            @(negedge clk);
            if (done) break;
            @(posedge clk); #1;
        end
        start  = 1'b0;
        clk_en = 1'b1;
        check32({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check32({name, "_result"}, result, exp_res);
        @(posedge clk); #1;
    endtask

    localparam logic [0:2][21:0] C_ONE  = {22'h100000, 22'h100000, 22'h100000};
    localparam logic [0:2][21:0] C_MONE = {22'h300000, 22'h300000, 22'h300000};
    localparam logic [0:2][21:0] C_ZERO = {22'h000000, 22'h000000, 22'h000000};
    localparam logic [0:2][31:0] H_ONE  = {32'h3F800000, 32'h3F800000, 32'h3F800000};
    localparam logic [0:2][31:0] S_FOUR = {32'h40800000, 32'h40800000, 32'h40800000};
    localparam logic [0:2][31:0] H_MIX  = {32'h3F000000, 32'h3F800000, 32'h40000000};

    initial begin
        int seen;
        rst = 1'b1; clk_en = 1'b1; start = 1'b0;
        set_ops(C_ZERO, '0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("reset_result", result, 32'h0);
        check32("reset_done", {31'b0, done}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_op("sum15", C_ONE, H_ONE, S_FOUR, 32'h41700000, DONE_LAT, 0, 0, 0);
        do_op("neg9", C_MONE, H_ONE, S_FOUR, 32'hC1100000, DONE_LAT, 0, 0, 0);
        do_op("cos0", C_ZERO, H_MIX, S_FOUR, 32'h40600000, DONE_LAT, 0, 0, 0);
        do_op("m2only", {22'h200000, 22'h0, 22'h0}, '0, {32'h3F800000, 32'h0, 32'h0},
              32'hC0000000, DONE_LAT, 0, 0, 0);
        do_op("half_cos", {22'h080000, 22'h080000, 22'h080000},
              {32'h3E800000, 32'h3E800000, 32'h3E800000},
              {32'h40400000, 32'h40400000, 32'h40400000}, 32'h40A80000, DONE_LAT, 0, 0, 0);
        do_op("mixed", {22'h0C0000, 22'h3C0000, 22'h1FFFFF},
              {32'h3F000000, 32'h3F800000, 32'h00000000},
              {32'h40000000, 32'h40800000, 32'h3F800000}, 32'h407FFFFC, DONE_LAT, 0, 0, 0);
        do_op("stall4", C_ONE, H_ONE, S_FOUR, 32'h41700000, DONE_LAT + 4, 5, 4, 0);
        do_op("repulse", C_ONE, H_ONE, S_FOUR, 32'h41700000, DONE_LAT, 0, 0, 5);

        // abort mid-RUN with a reset at c+6
        set_ops(C_MONE, H_ONE, S_FOUR);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) seen++;
        end
        check32("rst_abort_done", 32'(seen), 32'd0);
        check32("rst_abort_result", result, 32'h0);
        @(posedge clk); #1;

        do_op("after_rst", C_MONE, H_ONE, S_FOUR, 32'hC1100000, DONE_LAT, 0, 0, 0);
        do_op("b2b_a", C_ZERO, H_MIX, S_FOUR, 32'h40600000, DONE_LAT, 0, 0, 0);
        do_op("b2b_b", C_ONE, H_ONE, S_FOUR, 32'h41700000, DONE_LAT, 0, 0, 0);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stage_2_combine.md
# stage_2_combine

Second arithmetic stage of the three-operand summation datapath. It consumes the outputs of the first stage: three CORDIC cosine words (fixed point), three halved operands and three squared operands (IEEE-754 single). It computes `result = Σ(half_i + square_i × cos_i)` for i = one, two, three and returns one single-precision sum to the parent custom-instruction controller. It time-multiplexes one shared FP multiplier and one shared FP adder under a counter-driven schedule, so latency is fixed.

## Interface
Parameters:
- `FLT_DATA_WIDTH`, 32: float word width.
- `CORDIC_DATA_WIDTH`, 22: cosine word width, signed Q2.20.
- `MUL_LATENCY`, 3: `fp_mul` pipeline depth in cycles.
- `ADD_LATENCY`, 3: `fp_add` pipeline depth in cycles (must be ≥1).

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  reset; synchronous and active-high.
- `clk_en`  in  1  global advance enable.
- `start`  in  1  launch; sampled only in IDLE with `clk_en`=1.
- `cos_one`, `cos_two`, `cos_three`  in  22 each  cosine values, Q2.20.
- `half_one`, `half_two`, `half_three`  in  32 each  halved operands.
- `square_one`, `square_two`, `square_three`  in  32 each  squared operands.
- `result`  out  32  sum.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN on `start`&`clk_en`:
  - latch all nine inputs;
  - clear the schedule counter `k` to 0.
- RUN: `k` increments every enabled cycle. Issue slots, with start cycle = c:
  - mul_i: `square_i × float(cos_i)`, issued at c+1+i, for i = 0..2.
  - add_i: `half_i + prod_i`, issued at c+1+i+MUL_LATENCY; captures term_i.
  - sum01: `term0 + term1`, issued at c+2+MUL_LATENCY+ADD_LATENCY.
  - final: `sum01 + term2`, issued at c+2+MUL_LATENCY+2·ADD_LATENCY.
  - Final output captured into `result` at c+2+MUL_LATENCY+3·ADD_LATENCY; transition to DONE.
- DONE: `done`=1 for exactly one cycle, then return to IDLE. `result` holds until the next capture.
- Q2.20 → float conversion:
  - value = signed raw / 2^20;
  - sign/magnitude, leading-one detect, normalise;
  - exact, with no rounding (≤22 significant bits);
  - raw 0 → 0x00000000 (+0.0).
- NaN/Inf/denormal handling is whatever `fp_mul`/`fp_add` produce. This block does not inspect values.
- `start` in RUN or DONE is ignored; no queuing.

## Timing
- Latency: `done` high at cycle c+3+MUL_LATENCY+3·ADD_LATENCY. With defaults this is c+15.
- `clk_en`=0 freezes everything: FSM, `k`, latched operands and the FP unit pipelines (their enables are tied to `clk_en`). Each stalled cycle adds exactly one cycle of latency. `done` is never asserted while `clk_en`=0; a pending DONE waits for it.
- Reset values: state IDLE, `done`=0, `result`=0, `k`=0.
- Reset mid-RUN or mid-DONE aborts the operation with no `done` pulse. A `start` in the first enabled cycle after reset is accepted.
- `start` and `rst` asserted together: reset wins.

## Structure
- Shared package `cordic_pkg`:
  - state encodings;
  - Q2.20 format constants (FRAC_BITS=20);
  - default latencies.
- Sub-module `fix22_to_fp32`: combinational converter. One instance, with a mux selecting cos_i by issue slot.
- Instantiates the existing `fp_mul` and `fp_add` units (fixed latency, no valid signals).
- Term registers: three 32-bit; sum01 register: one 32-bit.

## Test plan
- All squares 4.0 (0x40800000), all halves 1.0 (0x3F800000), all cos 0x100000 (1.0) → `result`=0x41700000 (15.0); `done` at c+15.
- Same, with all cos 0x300000 (−1.0) → 0xC1100000 (−9.0).
- cos all 0, halves 0.5/1.0/2.0 → 0x40600000 (3.5); cos 0x200000 (−2.0) alone on operand one, square 1.0, others zero → 0xC0000000.
- `clk_en` low for 4 cycles mid-RUN → `done` at c+19, identical `result`; `done` width 1.
- `start` re-pulsed during RUN → ignored: single `done`, result unchanged; `rst` at c+6 → no `done`, `result`=0, next start completes normally.
- Back-to-back ops: second `start` in cycle after `done` → accepted, `done` 15 cycles later, first `result` held until then.
